// File: rtl/ssd_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed seven-segment display.
// Frame-synchronous double buffer for the digit codes, plus blanking for leading-zero suppression and blinking.
module ssd_scan_ctrl #(
    parameter int DIV_CNT      = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic       lz_en,
    input  logic [3:0] blink_mask,
    output logic [1:0] scan,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] out4,
    output logic       blank,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(DIV_CNT);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scan_q, scan_d;
    logic [3:0]       sh1_q, sh2_q, sh3_q, sh4_q;
    logic [3:0]       sh1_d, sh2_d, sh3_d, sh4_d;
    logic [3:0]       o1_q, o2_q, o3_q, o4_q;
    logic [3:0]       o1_d, o2_d, o3_d, o4_d;
    logic             pend_q, pend_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_ph_q, blk_ph_d;
    logic             tick_q, tick_d;
    logic             slot_edge, wrap;
    logic             lz_term, blink_term;

    assign slot_edge = (cnt_q == CNT_W'(DIV_CNT - 1));
    assign wrap      = slot_edge && (scan_q == 2'd3);

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        scan_d    = scan_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        sh3_d     = sh3_q;
        sh4_d     = sh4_q;
        o1_d      = o1_q;
        o2_d      = o2_q;
        o3_d      = o3_q;
        o4_d      = o4_q;
        pend_d    = pend_q;
        blk_cnt_d = blk_cnt_q;
        blk_ph_d  = blk_ph_q;
        tick_d    = wrap;

        if (slot_edge) begin
            cnt_d  = '0;
            scan_d = scan_q + 2'd1;
        end

        if (load) begin
            sh1_d  = in1;
            sh2_d  = in2;
            sh3_d  = in3;
            sh4_d  = in4;
            pend_d = 1'b1;
        end

        if (wrap) begin
            // A load coinciding with the wrap commits its own inputs, not the older shadow.
            if (load) begin
                o1_d = in1;
                o2_d = in2;
                o3_d = in3;
                o4_d = in4;
            end else if (pend_q) begin
                o1_d = sh1_q;
                o2_d = sh2_q;
                o3_d = sh3_q;
                o4_d = sh4_q;
            end
            pend_d = 1'b0;

            if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_d = '0;
                blk_ph_d  = ~blk_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            scan_q    <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            sh3_q     <= '0;
            sh4_q     <= '0;
            o1_q      <= '0;
            o2_q      <= '0;
            o3_q      <= '0;
            o4_q      <= '0;
            pend_q    <= 1'b0;
            blk_cnt_q <= '0;
            blk_ph_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            sh3_q     <= sh3_d;
            sh4_q     <= sh4_d;
            o1_q      <= o1_d;
            o2_q      <= o2_d;
            o3_q      <= o3_d;
            o4_q      <= o4_d;
            pend_q    <= pend_d;
            blk_cnt_q <= blk_cnt_d;
            blk_ph_q  <= blk_ph_d;
            tick_q    <= tick_d;
        end
    end

    // Rightmost digit is never suppressed so an all-zero value still shows "0".
    always_comb begin
        lz_term = 1'b0;
        case (scan_q)
            2'd3:    lz_term = (o4_q == 4'd0);
            2'd2:    lz_term = (o4_q == 4'd0) && (o3_q == 4'd0);
            2'd1:    lz_term = (o4_q == 4'd0) && (o3_q == 4'd0) && (o2_q == 4'd0);
            default: lz_term = 1'b0;
        endcase
        lz_term = lz_term && lz_en;
    end

    assign blink_term = blk_ph_q && blink_mask[scan_q];

    assign scan       = scan_q;
    assign out1       = o1_q;
    assign out2       = o2_q;
    assign out3       = o3_q;
    assign out4       = o4_q;
    assign blank      = blink_term || lz_term;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIV_CNT=4, BLINK_FRAMES=2.
module tb_ssd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic       lz_en = 1'b0;
    logic [3:0] blink_mask = '0;
    logic [1:0] scan;
    logic [3:0] out1, out2, out3, out4;
    logic       blank, frame_tick;

    int vecs = 0;
    int errs = 0;
    int c    = 0;
    logic [3:0] e1 = '0, e2 = '0, e3 = '0, e4 = '0;

    ssd_scan_ctrl #(.DIV_CNT(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .load(load),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .lz_en(lz_en), .blink_mask(blink_mask),
        .scan(scan), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .blank(blank), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected values after edge c counted from reset release: scan=(c/4)%4, wrap every 16, phase toggles every 2 frames.
    task automatic tick();
        int s;
        logic ph, lz;
        step();
        c++;
        s  = (c / 4) % 4;
        ph = ((c / 32) % 2) == 1;
        case (s)
            3:       lz = (e4 == 0);
            2:       lz = (e4 == 0) && (e3 == 0);
            1:       lz = (e4 == 0) && (e3 == 0) && (e2 == 0);
            default: lz = 1'b0;
        endcase
        chk("scan", 32'(scan), 32'(s));
        chk("frame_tick", 32'(frame_tick), 32'((c % 16) == 0));
        chk("out1", 32'(out1), 32'(e1));
        chk("out2", 32'(out2), 32'(e2));
        chk("out3", 32'(out3), 32'(e3));
        chk("out4", 32'(out4), 32'(e4));
        chk("blank", 32'(blank), 32'((ph && blink_mask[s]) || (lz && lz_en)));
    endtask

    task automatic run(input int n);
        while (c < n) tick();
    endtask

    task automatic drive(input logic [3:0] a4, input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1);
        load = 1'b1;
        in4 = a4; in3 = a3; in2 = a2; in1 = a1;
    endtask

    initial begin
        step();
        step();
        chk("rst_scan", 32'(scan), 0);
        chk("rst_out", {16'd0, out4, out3, out2, out1}, 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        rst = 1'b0;

        run(4);  drive(4'd1, 4'd2, 4'd3, 4'd4);
        run(5);  load = 1'b0;
        run(15); e1 = 4'd4; e2 = 4'd3; e3 = 4'd2; e4 = 4'd1;
        run(33); drive(4'd9, 4'd9, 4'd9, 4'd9);
        run(34); load = 1'b0;
        run(39); drive(4'd5, 4'd6, 4'd7, 4'd8);
        run(40); load = 1'b0;
        run(47); e1 = 4'd8; e2 = 4'd7; e3 = 4'd6; e4 = 4'd5;
        run(63); drive(4'd7, 4'd7, 4'd7, 4'd7);
        e1 = 4'd7; e2 = 4'd7; e3 = 4'd7; e4 = 4'd7;
        run(64); load = 1'b0;
        run(65); drive(4'd0, 4'd0, 4'd4, 4'd0);
        run(66); load = 1'b0;
        run(79); e1 = 4'd0; e2 = 4'd4; e3 = 4'd0; e4 = 4'd0;
        run(80); lz_en = 1'b1;
        run(96); drive(4'd0, 4'd0, 4'd0, 4'd0);
        run(97); load = 1'b0;
        run(111); e2 = 4'd0;
        run(128); lz_en = 1'b0; blink_mask = 4'b0001;
        run(193); drive(4'd1, 4'd1, 4'd1, 4'd1);
        run(194); load = 1'b0;
        run(198);

        rst = 1'b1;
        step();
        chk("mid_rst_scan", 32'(scan), 0);
        chk("mid_rst_out", {16'd0, out4, out3, out2, out1}, 0);
        chk("mid_rst_tick", 32'(frame_tick), 0);
        chk("mid_rst_blank", 32'(blank), 0);
        rst = 1'b0;
        c = 0;
        blink_mask = 4'b0000;
        run(33);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Sequencing controller for the 4-digit multiplexed seven-segment display driver.
- Generates the 2-bit digit-scan select from a refresh prescaler.
- Double-buffers the four BCD digit codes so updates apply only at frame boundaries (no tearing).
- Produces a blank strobe for leading-zero suppression and per-digit blinking; top level forces the anode control to 4'b1111 while blank=1.

Parameters:
- DIV_CNT, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
- BLINK_FRAMES, 125, full scan frames per blink half-period (125 x 4 ms = 0.5 s); legal range >= 1.

Parameters that depend on parameters:
- CNT_W = clog2(DIV_CNT).
- BLK_W = clog2(BLINK_FRAMES+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  single-cycle strobe; captures in1..in4 into the shadow buffer.
- in1  in  4  digit code, rightmost digit (scan 0).
- in2  in  4  digit code, scan 1.
- in3  in  4  digit code, scan 2.
- in4  in  4  digit code, leftmost digit (scan 3).
- lz_en  in  1  leading-zero suppression enable; sampled live.
- blink_mask  in  4  bit i=1 blinks digit at scan i; sampled live.
- scan  out  2  digit select to the display driver.
- out1..out4  out  4 each  committed (displayed) digit codes.
- blank  out  1  1 = current scan slot must be dark.
- frame_tick  out  1  one-cycle pulse after each frame wrap.

Interface (decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk edge; overrides all other inputs, including mid-frame and mid-pending):
  - prescaler cnt=0, scan=0.
  - out1..out4=0, shadow=0, pending=0.
  - blink_cnt=0, blink_phase=0, frame_tick=0.
- Prescaler:
  - cnt counts 0..DIV_CNT-1.
  - At the edge where cnt==DIV_CNT-1: cnt<=0 and scan<=scan+1 (mod 4, 3->0 wraps). This edge is a "slot edge".
  - Each scan value therefore persists exactly DIV_CNT cycles. First slot after reset is also DIV_CNT cycles.
- Frame wrap = slot edge with scan==3.
  - frame_tick=1 for the single cycle following the wrap edge; 0 otherwise.
- Load / double buffer:
  - load=1: shadow<=in1..in4, pending<=1.
  - Load while pending: shadow overwritten, last load wins.
  - At a frame wrap with pending=1: out1..out4<=shadow, pending<=0.
  - load=1 on the wrap edge itself: the in1..in4 values of that cycle commit directly to out1..out4 (bypassing shadow), and pending ends at 0.
  - Outputs out1..out4 change only at wrap edges (and reset).
- Blink:
  - blink_cnt counts frame wraps 0..BLINK_FRAMES-1.
  - At a wrap with blink_cnt==BLINK_FRAMES-1: blink_cnt<=0, blink_phase toggles.
- blank (combinational from registered scan/out* and live lz_en/blink_mask; valid in the same cycle as scan):
  - blink term: blink_phase & blink_mask[scan].
  - lz term, active only when lz_en=1:
    - scan 3: out4==0.
    - scan 2: out4==0 & out3==0.
    - scan 1: out4==0 & out3==0 & out2==0.
    - scan 0: never suppressed (a value of zero shows "0").
  - blank = blink term | lz term.
- Codes 10..15 pass through unmodified; they are nonzero for lz purposes.

Test Plan (DIV_CNT=4, BLINK_FRAMES=2 unless noted):
- Reset then free-run 32 cycles -> scan 0,1,2,3 each held 4 cycles, repeating; frame_tick high exactly at cycles 16 and 32 (1-cycle pulses); out1..out4=0, blank=0.
- Pulse load with in4..in1=1,2,3,4 at cycle 5 -> out* unchanged until the wrap edge at cycle 16, then out1=4, out2=3, out3=2, out4=1; pending clears.
- Two loads in one frame (9,9,9,9 then 5,6,7,8) -> only 5,6,7,8 commits at the wrap. Separately, load 7,7,7,7 exactly on the wrap edge -> commits that same edge.
- lz_en=1 with out4..out1=0,0,4,0 -> blank=1 in scan 3 and scan 2, blank=0 in scan 1 and scan 0. All-zero digits -> scan 0 unblanked.
- blink_mask=4'b0001 -> scan 0 blank follows blink_phase: 0 for frames 0-1, 1 for frames 2-3, toggling every 2 frames; other slots never blank.
- Assert rst mid-slot while pending=1 -> next cycle: scan=0, cnt=0, out*=0, pending=0; the old shadow data never commits.
